// File: rtl/scan_pkg.sv
// Shared defaults and constant helpers for the digit scan controller.
package scan_pkg;

  localparam int unsigned DEF_CLK_DIV        = 25000;
  localparam int unsigned DEF_NUM_DIGITS     = 7;
  localparam int unsigned DEF_BLANK_CYCLES   = 16;
  localparam bit          DEF_SEL_ACTIVE_LOW = 1'b1;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned scan_clog2(input longint unsigned v);
    int unsigned     r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV clocks while enabled.
module tick_gen
  import scan_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned      CNT_W   = (scan_clog2(CLK_DIV) < 1) ? 1 : scan_clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_d;

  // Next count; disabling clears the count so a restart waits a full period.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == CNT_MAX) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= tick_d;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed display digit scanner with mask skipping, hold and dead time.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
  parameter int unsigned NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int unsigned BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter bit          SEL_ACTIVE_LOW = DEF_SEL_ACTIVE_LOW,
  localparam int unsigned IDX_W = (scan_clog2(NUM_DIGITS) < 1) ? 1 : scan_clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  hold,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [IDX_W-1:0]      digit_idx,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  tick,
  output logic                  frame_done,
  output logic                  blank
);

  localparam int unsigned BLANK_W =
    (scan_clog2(BLANK_CYCLES + 1) < 1) ? 1 : scan_clog2(BLANK_CYCLES + 1);
  localparam logic [NUM_DIGITS-1:0] SEL_INACTIVE = SEL_ACTIVE_LOW ? '1 : '0;

  logic [IDX_W-1:0]      idx_d;
  logic [IDX_W-1:0]      cand;
  logic                  found;
  logic                  fd_d;
  logic [BLANK_W-1:0]    bcnt_q;
  logic [BLANK_W-1:0]    bcnt_d;
  logic [NUM_DIGITS-1:0] sel_d;

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // Next index search, wrap detection, dead-time and select decode.
  always_comb begin
    idx_d = digit_idx;
    cand  = '0;
    found = 1'b0;
    fd_d  = 1'b0;
    sel_d = '0;

    // Search forward from idx+1; the last candidate is idx itself.
    if (en && tick && !hold) begin
      for (int k = 1; k <= int'(NUM_DIGITS); k++) begin
        cand = IDX_W'((int'(digit_idx) + k) % int'(NUM_DIGITS));
        if (!found && digit_mask[cand]) begin
          found = 1'b1;
          idx_d = cand;
        end
      end
      fd_d = found && (idx_d <= digit_idx);
    end

    bcnt_d = (bcnt_q != '0) ? bcnt_q - BLANK_W'(1) : '0;
    if (idx_d != digit_idx) begin
      bcnt_d = BLANK_W'(BLANK_CYCLES);
    end

    if (en && (bcnt_d == '0) && digit_mask[idx_d]) begin
      sel_d[idx_d] = 1'b1;
    end
    sel_d = SEL_ACTIVE_LOW ? ~sel_d : sel_d;
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx  <= '0;
      frame_done <= 1'b0;
      bcnt_q     <= '0;
      blank      <= 1'b0;
      digit_sel  <= SEL_INACTIVE;
    end else begin
      digit_idx  <= idx_d;
      frame_done <= fd_d;
      bcnt_q     <= bcnt_d;
      blank      <= (bcnt_d != '0);
      digit_sel  <= sel_d;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl (CLK_DIV=4, 7 digits, 1 dead cycle, active-low).
module tb_digit_scan_ctrl;

  localparam int unsigned CLK_DIV        = 4;
  localparam int unsigned NUM_DIGITS     = 7;
  localparam int unsigned BLANK_CYCLES   = 1;
  localparam bit          SEL_ACTIVE_LOW = 1'b1;

  typedef struct {
    logic [2:0] idx;
    logic       fd;
    logic       blank;
    logic [6:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       hold;
  logic [6:0] mask;
  logic [2:0] digit_idx;
  logic [6:0] digit_sel;
  logic       tick;
  logic       frame_done;
  logic       blank;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  digit_scan_ctrl #(
    .CLK_DIV        (CLK_DIV),
    .NUM_DIGITS     (NUM_DIGITS),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .SEL_ACTIVE_LOW (SEL_ACTIVE_LOW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .hold       (hold),
    .digit_mask (mask),
    .digit_idx  (digit_idx),
    .digit_sel  (digit_sel),
    .tick       (tick),
    .frame_done (frame_done),
    .blank      (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count falling edges until tick is seen, bounded.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 20);
  endtask

  // Queue the expected result of the next tick, then let that tick happen.
  task automatic step(input logic [6:0] m, input logic h, input logic [2:0] ei,
                      input logic ef, input logic eb, input logic [6:0] es, input int lat);
    int n;
    mask = m;
    hold = h;
    q.push_back('{idx: ei, fd: ef, blank: eb, sel: es});
    wait_tick(n);
    check("tick_latency", n, lat);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: each tick is followed by an index update, then a settled select.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_tick", 32'(tick), 32'd0);
        end else begin
          e = q.pop_front();
          @(negedge clk);
          check("digit_idx", 32'(digit_idx), 32'(e.idx));
          check("frame_done", 32'(frame_done), 32'(e.fd));
          check("blank", 32'(blank), 32'(e.blank));
          @(negedge clk);
          check("digit_sel", 32'(digit_sel), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    int  n;
    bit  seen;
    rst_n = 1'b1;
    en    = 1'b0;
    hold  = 1'b0;
    mask  = 7'h7F;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idx", 32'(digit_idx), 32'd0);
    check("rst_sel", 32'(digit_sel), 32'h7F);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);

    // Full scan with every digit enabled.
    en    = 1'b1;
    rst_n = 1'b1;
    step(7'h7F, 1'b0, 3'd1, 1'b0, 1'b1, 7'h7D, 4);
    step(7'h7F, 1'b0, 3'd2, 1'b0, 1'b1, 7'h7B, 2);
    step(7'h7F, 1'b0, 3'd3, 1'b0, 1'b1, 7'h77, 2);
    step(7'h7F, 1'b0, 3'd4, 1'b0, 1'b1, 7'h6F, 2);
    step(7'h7F, 1'b0, 3'd5, 1'b0, 1'b1, 7'h5F, 2);
    step(7'h7F, 1'b0, 3'd6, 1'b0, 1'b1, 7'h3F, 2);
    step(7'h7F, 1'b0, 3'd0, 1'b1, 1'b1, 7'h7E, 2);

    // Sparse mask: digits 1, 4, 6.
    step(7'h52, 1'b0, 3'd1, 1'b0, 1'b1, 7'h7D, 2);
    step(7'h52, 1'b0, 3'd4, 1'b0, 1'b1, 7'h6F, 2);
    step(7'h52, 1'b0, 3'd6, 1'b0, 1'b1, 7'h3F, 2);
    step(7'h52, 1'b0, 3'd1, 1'b1, 1'b1, 7'h7D, 2);

    // Hold at digit 2 for three ticks.
    step(7'h7F, 1'b0, 3'd2, 1'b0, 1'b1, 7'h7B, 2);
    step(7'h7F, 1'b1, 3'd2, 1'b0, 1'b0, 7'h7B, 2);
    step(7'h7F, 1'b1, 3'd2, 1'b0, 1'b0, 7'h7B, 2);
    step(7'h7F, 1'b1, 3'd2, 1'b0, 1'b0, 7'h7B, 2);
    step(7'h7F, 1'b0, 3'd3, 1'b0, 1'b1, 7'h77, 2);

    // Mask cleared under the current digit, then a single-digit mask.
    mask = 7'h00;
    @(negedge clk);
    check("mask0_sel", 32'(digit_sel), 32'h7F);
    check("mask0_idx", 32'(digit_idx), 32'd3);
    step(7'h00, 1'b0, 3'd3, 1'b0, 1'b0, 7'h7F, 1);
    step(7'h00, 1'b0, 3'd3, 1'b0, 1'b0, 7'h7F, 2);
    step(7'h08, 1'b0, 3'd3, 1'b1, 1'b0, 7'h77, 2);
    step(7'h08, 1'b0, 3'd3, 1'b1, 1'b0, 7'h77, 2);

    // Disable for 10 clocks at digit 5.
    step(7'h7F, 1'b0, 3'd4, 1'b0, 1'b1, 7'h6F, 2);
    step(7'h7F, 1'b0, 3'd5, 1'b0, 1'b1, 7'h5F, 2);
    en   = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tick !== 1'b0) seen = 1'b1;
    end
    check("dis_tick_seen", 32'(seen), 32'd0);
    check("dis_sel", 32'(digit_sel), 32'h7F);
    check("dis_idx", 32'(digit_idx), 32'd5);
    check("dis_fd", 32'(frame_done), 32'd0);
    en = 1'b1;
    step(7'h7F, 1'b0, 3'd6, 1'b0, 1'b1, 7'h3F, 4);

    // Reset asserted during the dead time after moving to digit 4.
    mask = 7'h10;
    hold = 1'b0;
    q.push_back('{idx: 3'd4, fd: 1'b1, blank: 1'b1, sel: 7'h7F});
    wait_tick(n);
    check("tick_latency", n, 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_idx", 32'(digit_idx), 32'd0);
    check("arst_sel", 32'(digit_sel), 32'h7F);
    check("arst_blank", 32'(blank), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_fd", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    check("arst_tick_hold", 32'(tick), 32'd0);
    mask  = 7'h7F;
    rst_n = 1'b1;
    step(7'h7F, 1'b0, 3'd1, 1'b0, 1'b1, 7'h7D, 4);
    step(7'h7F, 1'b0, 3'd2, 1'b0, 1'b1, 7'h7B, 2);

    en = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
